// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS datapath, its ALU control and
// its main control state machine.
//   - opcode constants for the supported instruction subset
//   - control state encodings (also visible on the debug State port)
//   - encodings of the ALUOp, ALUSrcB and PCSrc select fields
//   - isSupportedOp(): true for every opcode the controller can sequence
// ---------------------------------------------------------------------------
package mc_pkg;

   // Instruction opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Control states; encodings 12-15 are never entered
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   // ALU operation class handed to the ALU control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXTSH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True for every opcode that has a defined execution sequence
   function automatic logic isSupportedOp(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main control state machine of the multicycle MIPS datapath. It sequences
// fetch, decode, execute, memory and writeback over 3-5 cycles and stalls in
// FETCH, MEMRD and MEMWR until memory signals MemReady.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; zeroes every output
//   Op        in   opcode from the instruction register (used in DECODE/MEMADR)
//   MemReady  in   memory finishes the current access this cycle
//   PCWE      out  unconditional PC write
//   Branch    out  conditional PC write, qualified outside by ALU zero
//   IorD      out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite  out  memory write strobe
//   IRWrite   out  instruction register load
//   RegDst    out  destination register select (0 = rt, 1 = rd)
//   MemtoReg  out  writeback data select (0 = ALUOut, 1 = MDR)
//   RegWrite  out  register file write
//   ALUSrcA   out  ALU A select (0 = PC, 1 = regA)
//   ALUSrcB   out  ALU B select (regB / 4 / signext / signext<<2)
//   ALUOp     out  ALU operation class (add / sub / funct)
//   PCSrc     out  next-PC source (ALU / ALUOut / jump target)
//   Illegal   out  one-cycle pulse when DECODE sees an unsupported opcode
//   State     out  current state for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPW-1:0]   Op,
   input  logic             MemReady,
   output logic             PCWE,
   output logic             Branch,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSrc,
   output logic             Illegal,
   output logic [STW-1:0]   State
);

   state_e state_q;
   state_e state_d;

   // State register: reset always restarts the machine at instruction fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: memory states hold until MemReady, DECODE dispatches
   // on the opcode class and MEMADR splits loads from stores
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (MemReady) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if ((Op == OP_LW) || (Op == OP_SW)) begin
               state_d = S_MEMADR;
            end else if (Op == OP_RTYPE) begin
               state_d = S_EXEC;
            end else if (Op == OP_BEQ) begin
               state_d = S_BRANCH;
            end else if (Op == OP_ADDI) begin
               state_d = S_ADDIEX;
            end else if (Op == OP_J) begin
               state_d = S_JUMP;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMADR: begin
            state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            if (MemReady) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWR: begin
            if (MemReady) begin
               state_d = S_FETCH;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB,
         S_ALUWB,
         S_BRANCH,
         S_ADDIWB,
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Output decode: a function of the current state only, except that the
   // FETCH-cycle IR/PC loads wait for MemReady and DECODE flags an unknown
   // opcode. Everything is held at zero while reset is asserted so that no
   // write strobe can escape during the reset cycle.
   always_comb begin
      PCWE     = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_REGB;
      ALUOp    = ALUOP_ADD;
      PCSrc    = PCSRC_ALU;
      Illegal  = 1'b0;
      State    = '0;
      if (!rst) begin
         State = STW'(state_q);
         case (state_q)
            S_FETCH: begin
               ALUSrcB = SRCB_FOUR;
               IRWrite = MemReady;
               PCWE    = MemReady;
            end
            S_DECODE: begin
               ALUSrcB = SRCB_SEXTSH2;
               Illegal = !isSupportedOp(Op);
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_SEXT;
            end
            S_MEMRD: begin
               IorD = 1'b1;
            end
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_SUB;
               PCSrc   = PCSRC_ALUOUT;
               Branch  = 1'b1;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_SEXT;
            end
            S_ADDIWB: begin
               RegWrite = 1'b1;
            end
            S_JUMP: begin
               PCSrc = PCSRC_JUMP;
               PCWE  = 1'b1;
            end
            default: begin
               State = STW'(state_q);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Instruction-level bench for the multicycle control FSM. The driver expands
// each instruction (opcode plus stall counts) into its expected per-cycle
// control word and queues it; a negedge monitor compares the DUT against
// the queue head every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

   logic       clk;
   logic       rst;
   logic [5:0] Op;
   logic       MemReady;
   logic       PCWE, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
   logic       RegWrite, ALUSrcA, Illegal;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic [3:0] State;

   logic [19:0] expQ[$];
   string       tagQ[$];
   int          total = 0;
   int          bad = 0;

   multicycle_ctrl_fsm #(.OPW(6), .STW(4)) dut (
      .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
      .PCWE(PCWE), .Branch(Branch), .IorD(IorD), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Control word layout:
   // {State, PCWE, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
   //  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal}
   function automatic logic [19:0] mkRow(
      input logic [3:0] st, input logic pcwe, input logic br,
      input logic iord, input logic memWr, input logic irWr,
      input logic regDst, input logic memToReg, input logic regWr,
      input logic srcA, input logic [1:0] srcB, input logic [1:0] aluOp,
      input logic [1:0] pcSrc, input logic ill);
      return {st, pcwe, br, iord, memWr, irWr, regDst, memToReg, regWr,
              srcA, srcB, aluOp, pcSrc, ill};
   endfunction

   function automatic logic [19:0] dutWord();
      return {State, PCWE, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
              RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal};
   endfunction

   function automatic bit legalOp(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
   endfunction

   // Monitor: every mid-cycle, the oldest queued expectation is due
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(tagQ.pop_front(), expQ.pop_front());
      end
   end

   task automatic checkOutput(input string tag, input logic [19:0] expWord);
      logic [19:0] got;
      got = dutWord();
      total++;
      if (got !== expWord) begin
         bad++;
         $display("[TB] FAIL %s: got=%05h want=%05h (State got=%0d want=%0d)",
                  tag, got, expWord, got[19:16], expWord[19:16]);
      end
   endtask

   // Drive one clock cycle of inputs and queue the control word it must show
   task automatic applyStimulus(input logic r, input logic [5:0] op,
                                input logic mr, input logic [19:0] expWord,
                                input string tag);
      rst      = r;
      Op       = op;
      MemReady = mr;
      expQ.push_back(expWord);
      tagQ.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] junkOp();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic junkReady();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic doFetch(input int stalls);
      for (int i = 0; i < stalls; i++) begin
         applyStimulus(1'b0, junkOp(), 1'b0,
            mkRow(4'd0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch_stall");
      end
      applyStimulus(1'b0, junkOp(), 1'b1,
         mkRow(4'd0,1,0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch");
   endtask

   // One whole instruction: fetch (with stalls), decode, then the
   // opcode-specific tail, with MemReady held low memStalls cycles on access
   task automatic runInstr(input logic [5:0] op, input int fetchStalls,
                           input int memStalls);
      doFetch(fetchStalls);
      applyStimulus(1'b0, op, junkReady(),
         mkRow(4'd1,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!legalOp(op)),
         "decode");
      case (op)
         6'b100011: begin
            applyStimulus(1'b0, op, junkReady(),
               mkRow(4'd2,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "lw_memadr");
            for (int i = 0; i < memStalls; i++) begin
               applyStimulus(1'b0, junkOp(), 1'b0,
                  mkRow(4'd3,0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memrd_stall");
            end
            applyStimulus(1'b0, junkOp(), 1'b1,
               mkRow(4'd3,0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memrd");
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd4,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), "memwb");
         end
         6'b101011: begin
            applyStimulus(1'b0, op, junkReady(),
               mkRow(4'd2,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "sw_memadr");
            for (int i = 0; i < memStalls; i++) begin
               applyStimulus(1'b0, junkOp(), 1'b0,
                  mkRow(4'd5,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memwr_stall");
            end
            applyStimulus(1'b0, junkOp(), 1'b1,
               mkRow(4'd5,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memwr");
         end
         6'b000000: begin
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd6,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), "exec");
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd7,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), "aluwb");
         end
         6'b000100: begin
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd8,0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), "branch");
         end
         6'b001000: begin
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd9,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "addiex");
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd10,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), "addiwb");
         end
         6'b000010: begin
            applyStimulus(1'b0, junkOp(), junkReady(),
               mkRow(4'd11,1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), "jump");
         end
         default: begin
         end
      endcase
   endtask

   function automatic logic [5:0] randomIllegal();
      logic [5:0] op;
      do begin
         op = 6'($urandom_range(0, 63));
      end while (legalOp(op));
      return op;
   endfunction

   // Directed scenarios first, then a long random instruction stream
   initial begin
      logic [5:0] op;
      rst = 1'b1;
      Op = 6'd0;
      MemReady = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, junkOp(), 1'b1, 20'd0, "reset0");
      applyStimulus(1'b1, junkOp(), 1'b1, 20'd0, "reset1");

      // Store abandoned by reset while MEMWR waits on memory
      doFetch(0);
      applyStimulus(1'b0, 6'b101011, 1'b1,
         mkRow(4'd1,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), "decode");
      applyStimulus(1'b0, 6'b101011, 1'b1,
         mkRow(4'd2,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "sw_memadr");
      applyStimulus(1'b0, junkOp(), 1'b0,
         mkRow(4'd5,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memwr_stall");
      applyStimulus(1'b1, junkOp(), 1'b1, 20'd0, "rst_in_memwr0");
      applyStimulus(1'b1, junkOp(), 1'b1, 20'd0, "rst_in_memwr1");

      runInstr(6'b100011, 0, 0);
      runInstr(6'b101011, 0, 2);
      runInstr(6'b000100, 0, 0);
      runInstr(6'b000010, 0, 0);
      runInstr(6'b111111, 0, 0);
      runInstr(6'b000000, 3, 0);
      runInstr(6'b001000, 0, 0);
      runInstr(6'b100011, 2, 3);

      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 6))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            default: op = randomIllegal();
         endcase
         runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      @(negedge clk);
      @(negedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: pending=%0d want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath.
- Produces the PCWE (unconditional PC write) and Branch request that the PC-enable OR gate combines with the ALU zero flag to form PCEn.
- Also drives every other datapath select and enable, sequencing fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Supports a memory-ready handshake so that slow memory stalls the sequence.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width (state exported for debug).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  OPW  instruction opcode, taken from the instruction register (valid from DECODE onward).
- MemReady  in  1  memory completes the current access this cycle.
- PCWE  out  1  unconditional PC write.
- Branch  out  1  conditional PC write; the OR gate qualifies it with zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = regA.
- ALUSrcB  out  2  ALU B select: 00 = regB, 01 = 4, 10 = signext, 11 = signext<<2.
- ALUOp  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct decode.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- Illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- State  out  STW  current state, for debug.

Behaviour:
- Reset: one clock, synchronous and active-high (clk, rst).
  - On a rising clk with rst=1, state <= FETCH.
  - While rst=1, all outputs are forced to 0 and State reads 0.
  - rst asserted mid-instruction abandons the instruction; no write strobe is asserted in the reset cycle.
- Moore machine: outputs are a pure decode of the state register (plus MemReady gating, below). Next state is registered.
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- States (encoding) and the outputs asserted in each; unlisted outputs are 0:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWE are asserted only when MemReady=1. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
    - LW or SW -> MEMADR
    - RTYPE -> EXEC
    - BEQ -> BRANCH
    - ADDI -> ADDIEX
    - J -> JUMP
    - any other -> FETCH, with Illegal=1 for this cycle only.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD(3): IorD=1. Waits for MemReady, then -> MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(5): IorD=1. MemWrite is held high until and including the MemReady=1 cycle, then -> FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - JUMP(11): PCSrc=10, PCWE=1 -> FETCH.
  - Encodings 12–15 are unreachable; if ever entered, go to FETCH with all outputs 0.
- PCWE and Branch are never asserted in the same cycle.
- Latency with MemReady=1 on every access:
  - J and BEQ: 3 cycles.
  - RTYPE, ADDI and SW: 4 cycles.
  - LW: 5 cycles.
  - Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady is ignored in every state except FETCH, MEMRD and MEMWR.
- Op is sampled only in DECODE and MEMADR. Changes to Op in other states have no effect.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - state encodings (S_FETCH … S_JUMP);
  - ALUOp, ALUSrcB and PCSrc encodings.
- The datapath and ALU control reuse the same package.
- Single module, no sub-module: the next-state logic and the output decode are two always blocks.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEMWR -> all outputs 0, MemWrite=0; with rst=0 and MemReady=1, the next cycle shows State=0, IRWrite=1, PCWE=1.
- LW, MemReady always 1 -> State sequence 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in the 5th cycle; PCWE=1 only in cycle 1.
- SW with MemReady low for 2 cycles in MEMWR -> State 0,1,2,5,5,5,0; MemWrite=1 for exactly 3 cycles; RegWrite never asserted.
- BEQ -> State 0,1,8,0; Branch=1 and PCSrc=01 only in cycle 3; PCWE=0 in that cycle.
- J followed by Op=111111 -> J: State 0,1,11 with PCWE=1 and PCSrc=10 in state 11. Illegal opcode: State 0,1,0 with Illegal=1 for exactly one cycle and no write strobes.
- RTYPE then ADDI back-to-back, with FETCH stalled 3 cycles by MemReady=0 -> FETCH holds with IRWrite=0 and PCWE=0 until MemReady=1. Then RTYPE gives ALUWB with RegDst=1, ALUOp=10 in EXEC, and ADDI gives ADDIWB with RegDst=0, ALUSrcB=10 in ADDIEX.
